serieparalelo_align: RTL and testbench

- Parametrised single-clock successor to the team's serial-to-parallel converter for the PCIe physical-layer receive path.
- Deserialises an MSB-first serial bit stream into WIDTH-bit words.
- Finds word alignment by hunting for a COMMA symbol anywhere in the stream, then declares lock after LOCK_COUNT consecutive aligned commas.
- Once locked, emits every received word with a one-cycle word strobe and flags non-comma words as valid data. Feeds the byte un-striping / descrambling stages.

---
 rtl/serieparalelo_align.sv | 123 ++++++++++++
 tb/tb_serieparalelo_align.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/serieparalelo_align.sv
// Serial-to-parallel receiver with comma-based word alignment.
// Hunts for COMMA at any bit offset, locks after LOCK_COUNT aligned commas, then emits words.
module serieparalelo_align #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter int               LOCK_COUNT = 4
) (
    input  logic             clk32f,
    input  logic             reset,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             word_strobe,
    output logic             active,
    output logic             comma
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [CW-1:0]    comma_cnt_reg, comma_cnt_next;
    logic [CW-1:0]    comma_cnt_inc;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             valid_reg, valid_next;
    logic             strobe_reg, strobe_next;
    logic             comma_reg, comma_next;
    logic             is_comma;
    logic             boundary;

    // The word under test includes the bit sampled on this same edge.
    always_comb begin
        sr_next  = {sr_reg[WIDTH-2:0], in};
        is_comma = (sr_next == COMMA);
        boundary = (bit_cnt_reg == BW'(WIDTH - 1));
        if (comma_cnt_reg == CW'(LOCK_COUNT))
            comma_cnt_inc = comma_cnt_reg;
        else
            comma_cnt_inc = comma_cnt_reg + CW'(1);
    end

    // State register and datapath registers.
    always_ff @(posedge clk32f) begin
        if (reset) begin
            state_reg     <= SEARCH;
            sr_reg        <= '0;
            bit_cnt_reg   <= '0;
            comma_cnt_reg <= '0;
            out_reg       <= '0;
            valid_reg     <= 1'b0;
            strobe_reg    <= 1'b0;
            comma_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            bit_cnt_reg   <= bit_cnt_next;
            comma_cnt_reg <= comma_cnt_next;
            out_reg       <= out_next;
            valid_reg     <= valid_next;
            strobe_reg    <= strobe_next;
            comma_reg     <= comma_next;
        end
    end

    // Next-state logic, including the alignment counters.
    always_comb begin
        state_next     = state_reg;
        comma_cnt_next = comma_cnt_reg;
        bit_cnt_next   = boundary ? '0 : bit_cnt_reg + BW'(1);
        case (state_reg)
            SEARCH: begin
                if (is_comma) begin
                    bit_cnt_next   = '0;
                    comma_cnt_next = CW'(1);
                    state_next     = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_next = comma_cnt_inc;
                        if (comma_cnt_inc == CW'(LOCK_COUNT))
                            state_next = LOCKED;
                    end else begin
                        // A failed boundary drops back to hunting; this word is not rescanned.
                        comma_cnt_next = '0;
                        state_next     = SEARCH;
                    end
                end
            end
            LOCKED: state_next = LOCKED;
            default: begin
                state_next     = SEARCH;
                comma_cnt_next = '0;
            end
        endcase
    end

    // Output logic: words are only published while locked, one strobe per boundary.
    always_comb begin
        out_next    = out_reg;
        valid_next  = valid_reg;
        comma_next  = comma_reg;
        strobe_next = 1'b0;
        if (state_reg == LOCKED && boundary) begin
            out_next    = sr_next;
            strobe_next = 1'b1;
            comma_next  = is_comma;
            valid_next  = !is_comma;
        end
    end

    assign out         = out_reg;
    assign valid       = valid_reg;
    assign word_strobe = strobe_reg;
    assign comma       = comma_reg;
    assign active      = (state_reg == LOCKED);

endmodule

// File: tb/tb_serieparalelo_align.sv
// Directed bench for serieparalelo_align: lock, offset lock, aborted lock, locked data and reset recovery.
module tb_serieparalelo_align;

    logic       clk32f = 1'b0;
    logic       reset  = 1'b1;
    logic       ser_in = 1'b0;
    logic [7:0] out;
    logic       valid;
    logic       word_strobe;
    logic       active;
    logic       comma;

    int n_vec = 0;
    int n_err = 0;

    serieparalelo_align #(.WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4)) dut (
        .clk32f      (clk32f),
        .reset       (reset),
        .in          (ser_in),
        .out         (out),
        .valid       (valid),
        .word_strobe (word_strobe),
        .active      (active),
        .comma       (comma)
    );

    always #5 clk32f = ~clk32f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bit, let the edge sample it, then observe just after the edge.
    task automatic send_bit(input logic b);
        ser_in = b;
        @(posedge clk32f);
        #1;
    endtask

    // Sends a word MSB first and checks how many strobes it produced.
    task automatic send_word(input logic [7:0] w, input int exp_strobes, input string tag);
        int n;
        n = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            if (word_strobe) n++;
        end
        $display("word %02h sent [%s] out=%02h valid=%0b comma=%0b active=%0b strobe=%0b",
                 w, tag, out, valid, comma, active, word_strobe);
        check({tag, "_strobes"}, n, exp_strobes);
        if (exp_strobes > 0) check({tag, "_strobe_last"}, word_strobe, 1);
    endtask

    task automatic check_word(input string tag, input logic [7:0] o, input logic v, input logic c);
        check({tag, "_out"},    out,    o);
        check({tag, "_valid"},  valid,  v);
        check({tag, "_comma"},  comma,  c);
        check({tag, "_active"}, active, 1);
    endtask

    task automatic do_reset(input int cycles);
        reset  = 1'b1;
        ser_in = 1'b0;
        repeat (cycles) @(posedge clk32f);
        #1;
        reset = 1'b0;
    endtask

    // Four aligned commas, then 55 and A3.
    task automatic lock_and_data(input string tag);
        for (int k = 0; k < 3; k++) send_word(8'hBC, 0, {tag, "_bc"});
        check({tag, "_active_after3"}, active, 0);
        send_word(8'hBC, 0, {tag, "_bc4"});
        check({tag, "_active_after4"}, active, 1);
        check({tag, "_out_after_lock"}, out, 8'h00);
        send_word(8'h55, 1, {tag, "_w55"});
        check_word({tag, "_w55"}, 8'h55, 1'b1, 1'b0);
        send_word(8'hA3, 1, {tag, "_wA3"});
        check_word({tag, "_wA3"}, 8'hA3, 1'b1, 1'b0);
    endtask

    initial begin
        do_reset(2);
        check("rst_out",    out,         8'h00);
        check("rst_valid",  valid,       0);
        check("rst_strobe", word_strobe, 0);
        check("rst_active", active,      0);
        check("rst_comma",  comma,       0);

        lock_and_data("t1");

        // Lock at a 3-bit offset
        do_reset(1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("t2_prefix_active", active, 0);
        lock_and_data("t2");

        // Lock attempt broken by 12, then a clean lock
        do_reset(1);
        send_word(8'hBC, 0, "t3_bc1");
        send_word(8'hBC, 0, "t3_bc2");
        send_word(8'h12, 0, "t3_12");
        check("t3_abort_active", active, 0);
        for (int k = 0; k < 3; k++) send_word(8'hBC, 0, "t3_bc");
        check("t3_active_after3", active, 0);
        send_word(8'hBC, 0, "t3_bc4");
        check("t3_active_after4", active, 1);
        send_word(8'h7E, 1, "t3_w7E");
        check_word("t3_w7E", 8'h7E, 1'b1, 1'b0);

        // Comma while locked, then data
        send_word(8'hBC, 1, "t4_bc");
        check_word("t4_bc", 8'hBC, 1'b0, 1'b1);
        send_word(8'h00, 1, "t4_00");
        check_word("t4_00", 8'h00, 1'b1, 1'b0);

        // Comma straddling a word boundary is ignored
        send_word(8'h0B, 1, "t5_0B");
        check_word("t5_0B", 8'h0B, 1'b1, 1'b0);
        send_word(8'hC0, 1, "t5_C0");
        check_word("t5_C0", 8'hC0, 1'b1, 1'b0);

        // Reset mid-word while locked
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        do_reset(1);
        check("t6_rst_out",    out,         8'h00);
        check("t6_rst_valid",  valid,       0);
        check("t6_rst_strobe", word_strobe, 0);
        check("t6_rst_active", active,      0);
        check("t6_rst_comma",  comma,       0);
        lock_and_data("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
